sensor_responder: RTL and testbench

SENSOR_RESPONDER -- requirements
Module: sensor_responder

---
 rtl/sensor_responder.sv | 202 ++++++++++++++++++++
 tb/tb_sensor_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_responder.sv
// sensor_responder: answers single-byte UART polls with the latched sensor
// reading followed by its CRC-8 (poly 0x07, init 0x00, MSB-first).
//
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   rx_data, rx_rdy, rx_clr  receive byte / valid flag / same-cycle clear pulse
//   tx_data, tx_wr, tx_busy  transmit byte / one-cycle strobe / UART busy
//   sensor_value/_valid      live sensor reading and its qualifier
//   alarm                    alarm condition, forces the 0xFF/0x0C reply
//   busy                     high whenever the responder is not idle
//   req_count                answered requests (wrapping)
//   drop_count               bytes discarded while busy (saturating)
//   err_timeout              one-cycle pulse when the UART never frees up
module sensor_responder #(
    parameter logic [2:0] NODE_ID        = 3'd1,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_clr,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    input  logic [7:0]  sensor_value,
    input  logic        sensor_valid,
    input  logic        alarm,
    output logic        busy,
    output logic [15:0] req_count,
    output logic [7:0]  drop_count,
    output logic        err_timeout
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_CRC_CALC  = 3'd2,
        S_SEND_DATA = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_SEND_CRC  = 3'd5,
        S_WAIT_CRC  = 3'd6
    } state_t;

    // One bit of the serial CRC-8 (x^8 + x^2 + x + 1), MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t           state_r, state_next_s;
    logic [7:0]       rx_byte_r, latch_r, crc_r, tx_data_r, data_byte_s, crc_byte_s, tx_data_s;
    logic             alarm_r, tx_wr_r, err_timeout_r, busy_r;
    logic             tx_wr_s, err_timeout_s, req_done_s, req_valid_s, tmo_hit_s, in_tx_s;
    logic             capture_s, drop_s;
    logic [2:0]       bit_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [15:0]      req_count_r;
    logic [7:0]       drop_count_r;

    assign req_valid_s = (rx_byte_r[7:3] == 5'd0) && (rx_byte_r[2:0] == NODE_ID);
    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
    assign in_tx_s     = (state_r == S_SEND_DATA) || (state_r == S_WAIT_DATA) ||
                         (state_r == S_SEND_CRC)  || (state_r == S_WAIT_CRC);
    // The alarm reply is a fixed 0xFF whose CRC byte is sent inverted.
    assign data_byte_s = alarm_r ? 8'hFF : latch_r;
    assign crc_byte_s  = alarm_r ? ~crc_r : crc_r;
    assign capture_s   = (state_r == S_IDLE) && rx_rdy;
    assign drop_s      = (state_r != S_IDLE) && rx_rdy;

    // rx_rdy must drop before the next edge, so the clear is combinational;
    // every byte is consumed (captured in IDLE, discarded otherwise).
    assign rx_clr      = rx_rdy & resetn;
    assign tx_data     = tx_data_r;
    assign tx_wr       = tx_wr_r;
    assign err_timeout = err_timeout_r;
    assign busy        = busy_r;
    assign req_count   = req_count_r;
    assign drop_count  = drop_count_r;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a timeout in any transmit state takes priority.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:      if (rx_rdy) state_next_s = S_DECODE; else state_next_s = S_IDLE;
            S_DECODE:    if (req_valid_s) state_next_s = S_CRC_CALC; else state_next_s = S_IDLE;
            S_CRC_CALC:  if (bit_cnt_r == 3'd7) state_next_s = S_SEND_DATA; else state_next_s = S_CRC_CALC;
            S_SEND_DATA: begin
                if (tmo_hit_s)     state_next_s = S_IDLE;
                else if (!tx_busy) state_next_s = S_WAIT_DATA;
                else               state_next_s = S_SEND_DATA;
            end
            // tmo_cnt_r == 0 marks the first WAIT cycle, where tx_busy is not yet trustworthy.
            S_WAIT_DATA: begin
                if (tmo_hit_s)                               state_next_s = S_IDLE;
                else if ((tmo_cnt_r != '0) && !tx_busy)      state_next_s = S_SEND_CRC;
                else                                         state_next_s = S_WAIT_DATA;
            end
            S_SEND_CRC: begin
                if (tmo_hit_s)     state_next_s = S_IDLE;
                else if (!tx_busy) state_next_s = S_WAIT_CRC;
                else               state_next_s = S_SEND_CRC;
            end
            S_WAIT_CRC: begin
                if (tmo_hit_s)                               state_next_s = S_IDLE;
                else if ((tmo_cnt_r != '0) && !tx_busy)      state_next_s = S_IDLE;
                else                                         state_next_s = S_WAIT_CRC;
            end
            default:     state_next_s = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered strobes and tx byte.
    always_comb begin
        tx_wr_s       = 1'b0;
        tx_data_s     = tx_data_r;
        err_timeout_s = 1'b0;
        req_done_s    = 1'b0;
        case (state_r)
            S_SEND_DATA, S_SEND_CRC: begin
                if (tmo_hit_s) begin
                    err_timeout_s = 1'b1;
                end else if (!tx_busy) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = (state_r == S_SEND_DATA) ? data_byte_s : crc_byte_s;
                end else begin
                    tx_wr_s = 1'b0;
                end
            end
            S_WAIT_DATA: begin
                if (tmo_hit_s) err_timeout_s = 1'b1; else err_timeout_s = 1'b0;
            end
            S_WAIT_CRC: begin
                if (tmo_hit_s) begin
                    err_timeout_s = 1'b1;
                end else if ((tmo_cnt_r != '0) && !tx_busy) begin
                    req_done_s = 1'b1;
                end else begin
                    req_done_s = 1'b0;
                end
            end
            default: begin
                tx_wr_s = 1'b0;
            end
        endcase
    end

    // Datapath: request capture, sensor latch, serial CRC, counters, outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_byte_r     <= 8'h00;
            latch_r       <= 8'h00;
            alarm_r       <= 1'b0;
            crc_r         <= 8'h00;
            bit_cnt_r     <= 3'd0;
            tmo_cnt_r     <= '0;
            tx_data_r     <= 8'h00;
            tx_wr_r       <= 1'b0;
            err_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            req_count_r   <= 16'h0000;
            drop_count_r  <= 8'h00;
        end else begin
            if (capture_s) rx_byte_r <= rx_data; else rx_byte_r <= rx_byte_r;
            if ((state_r == S_DECODE) && req_valid_s) begin
                if (sensor_valid) latch_r <= sensor_value; else latch_r <= latch_r;
                alarm_r <= alarm;
                crc_r   <= 8'h00;
            end else if (state_r == S_CRC_CALC) begin
                crc_r <= crc8_step(crc_r, data_byte_s[3'd7 - bit_cnt_r]);
            end else begin
                crc_r <= crc_r;
            end
            if (state_r == S_CRC_CALC) bit_cnt_r <= bit_cnt_r + 3'd1; else bit_cnt_r <= 3'd0;
            // Restart the per-state timer on every state change.
            if (state_next_s != state_r) tmo_cnt_r <= '0;
            else if (in_tx_s)            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            else                         tmo_cnt_r <= '0;
            tx_data_r     <= tx_data_s;
            tx_wr_r       <= tx_wr_s;
            err_timeout_r <= err_timeout_s;
            busy_r        <= (state_next_s != S_IDLE);
            if (req_done_s) req_count_r <= req_count_r + 16'd1; else req_count_r <= req_count_r;
            if (drop_s && (drop_count_r != 8'hFF)) drop_count_r <= drop_count_r + 8'd1;
            else                                   drop_count_r <= drop_count_r;
        end
    end

endmodule

// File: tb/tb_sensor_responder.sv
module tb_sensor_responder;

    logic        clock = 1'b0;
    logic        resetn, rx_rdy, rx_clr, tx_wr, tx_busy, sensor_valid, alarm, busy, err_timeout;
    logic [7:0]  rx_data, tx_data, sensor_value, drop_count;
    logic [15:0] req_count;

    always #5 clock = ~clock;

    sensor_responder #(.NODE_ID(3'd1), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_clr(rx_clr),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .sensor_value(sensor_value),
        .sensor_valid(sensor_valid), .alarm(alarm), .busy(busy), .req_count(req_count),
        .drop_count(drop_count), .err_timeout(err_timeout)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_data[$];
    int          obs_cyc[$];
    int          tmo_cyc, tmo_pulses;
    logic        clr_seen, inj_clr_seen;
    logic [7:0]  model_latch = 8'h00;
    logic [15:0] model_req = 16'h0000;
    logic [7:0]  model_drop = 8'h00;

    function automatic logic [7:0] crc8_ref(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Reference model of one valid request: push expected data and CRC bytes.
    task automatic push_request(input logic [7:0] val, input logic val_ok, input logic alm);
        logic [7:0] d;
        if (val_ok) model_latch = val;
        d = alm ? 8'hFF : model_latch;
        exp_q.push_back(d);
        exp_q.push_back(alm ? ~crc8_ref(8'hFF) : crc8_ref(d));
    endtask

    // Present one byte for exactly one capture edge; returns on the negedge after it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1 clr_seen = rx_clr;
        @(negedge clock);
        rx_rdy = 1'b0;
    endtask

    // Watch n cycles, recording strobes (cycle index relative to the capture
    // edge) and timeout pulses; models a UART that goes busy one cycle after
    // each strobe for busy_len cycles, or stays busy forever when stuck.
    task automatic run_cycles(input int n, input int busy_len, input logic stuck,
                              input int inj_at, input logic [7:0] inj_byte);
        int  left;
        logic pend;
        left = 0; pend = 1'b0;
        obs_data.delete(); obs_cyc.delete();
        tmo_cyc = -1; tmo_pulses = 0; inj_clr_seen = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (left > 0) left--;
            if (pend) begin left = busy_len; pend = 1'b0; end
            if (!stuck) tx_busy = (left > 0);
            rx_rdy = 1'b0;
            if (tx_wr === 1'b1) begin
                obs_data.push_back(tx_data);
                obs_cyc.push_back(k);
                if (stuck) tx_busy = 1'b1; else pend = 1'b1;
            end
            if (err_timeout === 1'b1) begin
                tmo_pulses++;
                if (tmo_cyc < 0) tmo_cyc = k;
            end
            if (k == inj_at) begin
                rx_data = inj_byte;
                rx_rdy  = 1'b1;
                #1 inj_clr_seen = rx_clr;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx_rdy = 1'b1; rx_data = 8'h01; tx_busy = 1'b0;
        sensor_value = 8'h00; sensor_valid = 1'b0; alarm = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (rx_clr !== 1'b0) begin failures++; $display("FAIL reset_rx_clr got %0h want 0", rx_clr); end
        checks++; if (tx_wr !== 1'b0) begin failures++; $display("FAIL reset_tx_wr got %0h want 0", tx_wr); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %0h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0h want 0", busy); end
        checks++; if (req_count !== 16'h0000) begin failures++; $display("FAIL reset_req_count got %0h want 0", req_count); end
        checks++; if (drop_count !== 8'h00) begin failures++; $display("FAIL reset_drop_count got %0h want 0", drop_count); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got %0h want 0", err_timeout); end
        rx_rdy = 1'b0;
        @(negedge clock); resetn = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %0h want 0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        sensor_value = 8'h01; sensor_valid = 1'b1; alarm = 1'b0;
        model_latch = 8'h01;
        exp_q.push_back(8'h01); exp_q.push_back(8'h07);
        send_byte(8'h01);
        checks++; if (clr_seen !== 1'b1) begin failures++; $display("FAIL basic_rx_clr got %0h want 1", clr_seen); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_capture got %0h want 1", busy); end
        run_cycles(20, 0, 1'b0, -1, 8'h00);
        model_req++;
        checks++; if (obs_data.size() != 2) begin failures++; $display("FAIL basic_strobe_count got %0d want 2", obs_data.size()); end
        checks++; if (obs_cyc.size() > 0 && obs_cyc[0] != 10) begin failures++; $display("FAIL basic_latency got %0d want 10", obs_cyc[0]); end
        checks++; if (obs_cyc.size() > 1 && obs_cyc[1] != 13) begin failures++; $display("FAIL basic_crc_cycle got %0d want 13", obs_cyc[1]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data.size() == 0) begin failures++; $display("FAIL basic_byte missing, want %0h", e); end
            else if (obs_data[0] !== e) begin failures++; $display("FAIL basic_byte got %0h want %0h", obs_data[0], e); void'(obs_data.pop_front()); end
            else void'(obs_data.pop_front());
        end
        checks++; if (req_count !== model_req) begin failures++; $display("FAIL basic_req_count got %0h want %0h", req_count, model_req); end
        checks++; if (tx_data !== 8'h07) begin failures++; $display("FAIL basic_tx_data_hold got %0h want 07", tx_data); end
        checks++; if (busy !== 1'b0 || tmo_pulses != 0) begin failures++; $display("FAIL basic_idle busy %0h timeouts %0d want 0/0", busy, tmo_pulses); end
    endtask

    task automatic test_invalid();
        logic [7:0] reqs [2];
        reqs[0] = 8'h02; reqs[1] = 8'h09;
        for (int i = 0; i < 2; i++) begin
            send_byte(reqs[i]);
            run_cycles(20, 0, 1'b0, -1, 8'h00);
            checks++; if (obs_data.size() != 0) begin failures++; $display("FAIL invalid_%0h strobes got %0d want 0", reqs[i], obs_data.size()); end
            checks++; if (req_count !== model_req || drop_count !== model_drop) begin failures++; $display("FAIL invalid_%0h counters got %0h/%0h want %0h/%0h", reqs[i], req_count, drop_count, model_req, model_drop); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL invalid_%0h busy got %0h want 0", reqs[i], busy); end
        end
    endtask

    // Shared body for scenarios whose bytes come from the scoreboard queue.
    task automatic check_bytes(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data.size() == 0) begin failures++; $display("FAIL %s_byte missing, want %0h", name, e); end
            else if (obs_data[0] !== e) begin failures++; $display("FAIL %s_byte got %0h want %0h", name, obs_data[0], e); void'(obs_data.pop_front()); end
            else void'(obs_data.pop_front());
        end
        checks++; if (obs_data.size() != 0) begin failures++; $display("FAIL %s_extra_bytes got %0d want 0", name, obs_data.size()); end
    endtask

    task automatic test_alarm();
        sensor_value = 8'h01; sensor_valid = 1'b1; alarm = 1'b1;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h0C);
        model_latch = 8'h01;
        send_byte(8'h01);
        run_cycles(20, 0, 1'b0, -1, 8'h00);
        model_req++;
        check_bytes("alarm");
        checks++; if (req_count !== model_req) begin failures++; $display("FAIL alarm_req_count got %0h want %0h", req_count, model_req); end
        alarm = 1'b0;
    endtask

    task automatic test_latch_hold();
        sensor_value = 8'hA5; sensor_valid = 1'b1;
        push_request(sensor_value, sensor_valid, 1'b0);
        send_byte(8'h01);
        run_cycles(20, 0, 1'b0, -1, 8'h00);
        model_req++;
        check_bytes("latch_new");
        sensor_value = 8'h3C; sensor_valid = 1'b0;
        push_request(sensor_value, sensor_valid, 1'b0);
        send_byte(8'h01);
        run_cycles(20, 0, 1'b0, -1, 8'h00);
        model_req++;
        check_bytes("latch_hold");
        sensor_valid = 1'b1;
    endtask

    task automatic test_drop_during_crc();
        sensor_value = 8'h5A;
        push_request(sensor_value, 1'b1, 1'b0);
        send_byte(8'h01);
        run_cycles(20, 0, 1'b0, 3, 8'h01);
        model_req++; model_drop++;
        checks++; if (inj_clr_seen !== 1'b1) begin failures++; $display("FAIL drop_rx_clr got %0h want 1", inj_clr_seen); end
        checks++; if (obs_cyc.size() != 2 || obs_cyc[0] != 10) begin failures++; $display("FAIL drop_timing strobes %0d want 2 at 10", obs_cyc.size()); end
        check_bytes("drop");
        checks++; if (drop_count !== model_drop || req_count !== model_req) begin failures++; $display("FAIL drop_counters got %0h/%0h want %0h/%0h", drop_count, req_count, model_drop, model_req); end
    endtask

    task automatic test_busy_uart();
        sensor_value = 8'hC3;
        push_request(sensor_value, 1'b1, 1'b0);
        send_byte(8'h01);
        run_cycles(40, 3, 1'b0, -1, 8'h00);
        model_req++;
        checks++; if (obs_cyc.size() != 2 || obs_cyc[1] != 16) begin failures++; $display("FAIL busy_crc_cycle got %0d strobes, want CRC at 16", obs_cyc.size()); end
        check_bytes("busy");
        checks++; if (req_count !== model_req || busy !== 1'b0) begin failures++; $display("FAIL busy_done req %0h busy %0h want %0h/0", req_count, busy, model_req); end
    endtask

    task automatic test_timeout();
        sensor_value = 8'h11;
        push_request(sensor_value, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        send_byte(8'h01);
        run_cycles(32, 0, 1'b1, 29, 8'h01);
        model_drop++;
        checks++; if (tmo_pulses != 1 || tmo_cyc != 30) begin failures++; $display("FAIL timeout_pulse got %0d pulses at %0d want 1 at 30", tmo_pulses, tmo_cyc); end
        check_bytes("timeout");
        checks++; if (req_count !== model_req) begin failures++; $display("FAIL timeout_req_count got %0h want %0h", req_count, model_req); end
        checks++; if (busy !== 1'b0 || drop_count !== model_drop) begin failures++; $display("FAIL timeout_idle busy %0h drop %0h want 0/%0h", busy, drop_count, model_drop); end
        tx_busy = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        sensor_value = 8'h22;
        push_request(sensor_value, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        send_byte(8'h01);
        run_cycles(12, 5, 1'b0, -1, 8'h00);
        check_bytes("reset_mid_data");
        @(negedge clock);
        resetn = 1'b0; tx_busy = 1'b0;
        #1;
        checks++; if (tx_wr !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL reset_mid_outputs wr %0h data %0h busy %0h tmo %0h want 0", tx_wr, tx_data, busy, err_timeout); end
        checks++; if (req_count !== 16'h0000 || drop_count !== 8'h00) begin failures++; $display("FAIL reset_mid_counters got %0h/%0h want 0/0", req_count, drop_count); end
        model_req = 16'h0000; model_drop = 8'h00; model_latch = 8'h00;
        @(negedge clock); resetn = 1'b1;
        run_cycles(25, 0, 1'b0, -1, 8'h00);
        checks++; if (obs_data.size() != 0) begin failures++; $display("FAIL reset_mid_no_crc got %0d strobes want 0", obs_data.size()); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 18; r++) begin
            send_byte(8'h01);
            rx_data = 8'h00; rx_rdy = 1'b1;
            repeat (15) @(negedge clock);
            rx_rdy = 1'b0;
            model_req++;
            model_drop = (model_drop > 8'd240) ? 8'hFF : model_drop + 8'd15;
        end
        checks++; if (drop_count !== model_drop) begin failures++; $display("FAIL b2b_drop_saturate got %0h want %0h", drop_count, model_drop); end
        checks++; if (req_count !== model_req) begin failures++; $display("FAIL b2b_req_count got %0h want %0h", req_count, model_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_alarm();
        test_latch_hold();
        test_drop_during_crc();
        test_busy_uart();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
